// File: rtl/lstm_act_pkg.sv
// lstm_act_pkg: mode encodings, default number formats and the LUT entry rounding rule
// shared by the activation unit and its ROM.
package lstm_act_pkg;
    typedef enum logic {ACT_SIGMOID = 1'b0, ACT_TANH = 1'b1} act_mode_e;
    localparam int IN_WIDTH   = 12;
    localparam int IN_FRAC    = 6;
    localparam int LUT_SIZE   = 384;
    localparam int ADDR_WIDTH = 9;
    localparam int OUT_WIDTH  = 16;
    localparam int OUT_FRAC   = 14;
    localparam int TAG_WIDTH  = 4;
    localparam int ONE        = 1 << OUT_FRAC;
    function automatic int lut_entry(input bit tanh_fn, input int i, input int in_frac, input int out_frac);
        real x, f;
        x = real'(i) / real'(1 << in_frac);
        f = tanh_fn ? 1.0 - 2.0 / ($exp(2.0 * x) + 1.0) : 1.0 / (1.0 + $exp(-x));
        return $rtoi(f * real'(1 << out_frac) + 0.5);
    endfunction
endpackage

// File: rtl/lstm_act_rom.sv
// lstm_act_rom: sigmoid table followed by tanh table, one registered read port with enable.
// Contents are produced from the rounding rule at elaboration; they are never reset.
module lstm_act_rom
    import lstm_act_pkg::*;
#(
    parameter int LUT_SIZE = lstm_act_pkg::LUT_SIZE,
    parameter int IN_FRAC  = lstm_act_pkg::IN_FRAC,
    parameter int OUT_FRAC = lstm_act_pkg::OUT_FRAC,
    localparam int DEPTH   = 2 * LUT_SIZE,
    localparam int WIDTH   = OUT_FRAC + 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] tbl [DEPTH];
    logic [WIDTH-1:0] rd_d, rd_q;
    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        assign tbl[g] = WIDTH'(lut_entry(g >= LUT_SIZE, g >= LUT_SIZE ? g - LUT_SIZE : g, IN_FRAC, OUT_FRAC));
    end
    always_comb begin
        rd_d = tbl[addr];
    end
    always_ff @(posedge clk) begin
        if (en) rd_q <= rd_d;
    end
    assign rd_data = rd_q;
endmodule

// File: rtl/lstm_activation_unit.sv
// lstm_activation_unit: 3-stage streaming sigmoid/tanh (fold to magnitude, LUT read,
// symmetry + saturation) with a single stall enable driven by the output handshake.
module lstm_activation_unit
    import lstm_act_pkg::*;
#(
    parameter int IN_WIDTH   = lstm_act_pkg::IN_WIDTH,
    parameter int IN_FRAC    = lstm_act_pkg::IN_FRAC,
    parameter int LUT_SIZE   = lstm_act_pkg::LUT_SIZE,
    parameter int ADDR_WIDTH = lstm_act_pkg::ADDR_WIDTH,
    parameter int OUT_WIDTH  = lstm_act_pkg::OUT_WIDTH,
    parameter int OUT_FRAC   = lstm_act_pkg::OUT_FRAC,
    parameter int TAG_WIDTH  = lstm_act_pkg::TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_sat
);
    localparam int ROM_AW = $clog2(2 * LUT_SIZE);
    localparam logic [OUT_WIDTH-1:0] ONE_V = OUT_WIDTH'(1 << OUT_FRAC);

    logic en;
    logic [IN_WIDTH:0] x_ext, mag;
    logic a_valid_d, a_valid_q, a_sign_d, a_sign_q, a_mode_d, a_mode_q, a_sat_d, a_sat_q;
    logic [ADDR_WIDTH-1:0] a_addr_d, a_addr_q;
    logic [TAG_WIDTH-1:0] a_tag_d, a_tag_q, b_tag_d, b_tag_q, out_tag_d, out_tag_q;
    logic b_valid_d, b_valid_q, b_sign_d, b_sign_q, b_mode_d, b_mode_q, b_sat_d, b_sat_q;
    logic out_valid_d, out_valid_q, out_sat_d, out_sat_q;
    logic [OUT_WIDTH-1:0] v, out_data_d, out_data_q;
    logic [ROM_AW-1:0] rom_addr;
    logic [OUT_FRAC:0] rom_data;

    // Magnitude is one bit wider so the most negative input folds without overflow.
    always_comb begin
        en          = ~out_valid_q | out_ready;
        x_ext       = {in_data[IN_WIDTH-1], in_data};
        mag         = x_ext[IN_WIDTH] ? -x_ext : x_ext;
        a_valid_d   = in_valid;
        a_sign_d    = in_data[IN_WIDTH-1];
        a_mode_d    = in_mode;
        a_tag_d     = in_tag;
        a_sat_d     = mag >= (IN_WIDTH+1)'(LUT_SIZE);
        a_addr_d    = a_sat_d ? ADDR_WIDTH'(LUT_SIZE - 1) : mag[ADDR_WIDTH-1:0];
        rom_addr    = a_mode_q ? ROM_AW'(LUT_SIZE) + ROM_AW'(a_addr_q) : ROM_AW'(a_addr_q);
        b_valid_d   = a_valid_q;
        b_sign_d    = a_sign_q;
        b_mode_d    = a_mode_q;
        b_tag_d     = a_tag_q;
        b_sat_d     = a_sat_q;
        v           = b_sat_q ? ONE_V : OUT_WIDTH'(rom_data);
        out_data_d  = b_mode_q == ACT_TANH ? (b_sign_q ? -v : v) : (b_sign_q ? ONE_V - v : v);
        out_valid_d = b_valid_q;
        out_tag_d   = b_tag_q;
        out_sat_d   = b_sat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            a_valid_q   <= a_valid_d;
            a_sign_q    <= a_sign_d;
            a_mode_q    <= a_mode_d;
            a_tag_q     <= a_tag_d;
            a_sat_q     <= a_sat_d;
            a_addr_q    <= a_addr_d;
            b_valid_q   <= b_valid_d;
            b_sign_q    <= b_sign_d;
            b_mode_q    <= b_mode_d;
            b_tag_q     <= b_tag_d;
            b_sat_q     <= b_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_sat_q   <= out_sat_d;
        end
    end

    lstm_act_rom #(
        .LUT_SIZE(LUT_SIZE),
        .IN_FRAC (IN_FRAC),
        .OUT_FRAC(OUT_FRAC)
    ) u_rom (
        .clk    (clk),
        .en     (en),
        .addr   (rom_addr),
        .rd_data(rom_data)
    );

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_lstm_activation_unit.sv
// tb_lstm_activation_unit: scoreboard bench; the driver pushes expected results from a
// real-arithmetic model, an independent monitor pops and compares on every output transfer.
module tb_lstm_activation_unit;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
    logic [11:0] in_data = '0;
    logic [3:0] in_tag = '0;
    logic in_ready, out_valid, out_sat;
    logic [15:0] out_data;
    logic [3:0] out_tag;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit rand_rdy = 1'b0, lat_chk = 1'b0;

    typedef struct {logic [15:0] d; logic [3:0] t; logic s; int acc;} exp_t;
    exp_t sb[$];

    lstm_activation_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // f(x) straight from the math: rounded |x| entry, then symmetry, saturation outside [0,6).
    function automatic void model(input logic [11:0] x, input bit m, output logic [15:0] d, output logic s);
        int xi = int'($signed(x));
        int a = xi < 0 ? -xi : xi;
        real r = real'(a) / 64.0;
        real f = m ? ($exp(r) - $exp(-r)) / ($exp(r) + $exp(-r)) : 1.0 / (1.0 + $exp(-r));
        int e;
        s = a >= 384;
        e = s ? 16384 : $rtoi(f * 16384.0 + 0.5);
        d = 16'(xi < 0 ? (m ? -e : 16384 - e) : e);
    endfunction

    task automatic send_exp(input logic [11:0] x, input bit m, input logic [3:0] t, input logic [15:0] d, input logic s);
        bit acc = 1'b0;
        in_valid = 1'b1; in_data = x; in_mode = m; in_tag = t;
        for (int w = 0; w < 1000 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back('{d, t, s, cyc});
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: tag %0h never accepted", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [11:0] x, input bit m, input logic [3:0] t);
        logic [15:0] d;
        logic s;
        model(x, m, d, s);
        send_exp(x, m, t, d, s);
    endtask

    task automatic drain();
        for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
        #1;
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [15:0] pd;
        logic [3:0] pt;
        bit stall = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) stall = 1'b0;
            else begin
                if (stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, pd);
                    check("stall_tag", out_tag, pt);
                end
                if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_out: got tag %0h data %0h, required no output", out_tag, out_data);
                    end else begin
                        e = sb.pop_front();
                        check("data", out_data, e.d);
                        check("tag", out_tag, e.t);
                        check("sat", out_sat, e.s);
                        if (lat_chk) check("latency", cyc - e.acc, 3);
                    end
                end
                stall = out_valid && !out_ready;
                pd = out_data;
                pt = out_tag;
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic s;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        lat_chk = 1'b1;
        send_exp(12'd0,   0, 4'd1, 16'd8192,  0);
        send_exp(12'd64,  0, 4'd2, 16'd11978, 0);
        send_exp(12'hFC0, 0, 4'd3, 16'd4406,  0);
        send_exp(12'd0,   1, 4'd4, 16'd0,     0);
        send_exp(12'd64,  1, 4'd5, 16'd12478, 0);
        send_exp(12'hFC0, 1, 4'd6, 16'hCF42,  0);
        send_exp(12'd400, 0, 4'd7, 16'd16384, 1);
        send_exp(12'h800, 0, 4'd8, 16'd0,     1);
        send_exp(12'hE70, 1, 4'd9, 16'hC000,  1);
        model(12'd383, 0, d, s);
        send_exp(12'd383, 0, 4'd10, d, 0);
        send_exp(12'd384, 0, 4'd11, 16'd16384, 1);
        drain();
        lat_chk = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(12'($urandom), i[0], 4'(i));
        drain();
        rand_rdy = 1'b0; out_ready = 1'b1;
        send(12'd100, 0, 4'd12);
        send(12'hF00, 1, 4'd13);
        send(12'd5, 0, 4'd14);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        rand_rdy = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 4096; x++) send(12'(x), m[0], 4'(x));
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
